mo_ctrl: RTL and testbench

- Sequencing FSM for the matrix-operation engine: computes Y = A·X + B with A n×r, X r×n, B and Y n×n.
- Issues the opcode/index stream to the shared memory port and fetches n and r.
- Drives the control strobes of a separate multiply-accumulate datapath that holds the operand register and accumulator.
- Contains no arithmetic on data words; asserts fin when the last Y element has been written.

---
 rtl/mo_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_mo_ctrl.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/mo_ctrl.sv
// mo_ctrl: sequencing FSM for Y = A*X + B (A n x r, X r x n, B/Y n x n).
// Fetches n and r, walks the memory opcode/index stream element by element
// (row-major, col fastest) and drives the strobes of an external MAC datapath.
// Ports:
//   clk, reset (async, active low)
//   in_data  : memory read data, sampled only while fetching n and r
//   opcode   : 000 GET_N, 001 GET_R, 010 READ_A, 011 READ_X, 100 READ_B,
//              101 WRITE_Y, 111 IDLE
//   i, j     : row/column index of the current access
//   ld_a, mac, add_b, acc_clr : one-hot datapath strobes tied to the opcode
//   fin      : sticky completion flag
module mo_ctrl #(
  parameter int unsigned W = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] in_data,
  output logic [2:0]   opcode,
  output logic [W-1:0] i,
  output logic [W-1:0] j,
  output logic         ld_a,
  output logic         mac,
  output logic         add_b,
  output logic         acc_clr,
  output logic         fin
);

  localparam logic [2:0] OP_GET_N  = 3'b000;
  localparam logic [2:0] OP_GET_R  = 3'b001;
  localparam logic [2:0] OP_READ_A = 3'b010;
  localparam logic [2:0] OP_READ_X = 3'b011;
  localparam logic [2:0] OP_READ_B = 3'b100;
  localparam logic [2:0] OP_WR_Y   = 3'b101;
  localparam logic [2:0] OP_IDLE   = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE, S_GET_N, S_GET_R, S_RD_A, S_RD_X, S_RD_B, S_WR_Y, S_DONE
  } state_t;

  state_t       state_q, state_d;
  logic [W-1:0] n_q, n_d, r_q, r_d;
  logic [W-1:0] row_q, row_d, col_q, col_d, k_q, k_d;
  logic [2:0]   opcode_q, opcode_d;
  logic [W-1:0] i_q, i_d, j_q, j_d;
  logic         ld_a_q, ld_a_d, mac_q, mac_d, add_b_q, add_b_d;
  logic         acc_clr_q, acc_clr_d, fin_q, fin_d;
  logic         last_elem;

  // Next state and counters.
  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    r_d       = r_q;
    row_d     = row_q;
    col_d     = col_q;
    k_d       = k_q;
    last_elem = 1'b0;
    case (state_q)
      S_IDLE:  state_d = S_GET_N;
      S_GET_N: begin
        n_d     = in_data;
        state_d = S_GET_R;
      end
      S_GET_R: begin
        r_d   = in_data;
        row_d = '0;
        col_d = '0;
        k_d   = '0;
        if (n_q == '0)          state_d = S_DONE;
        else if (in_data == '0) state_d = S_RD_B;
        else                    state_d = S_RD_A;
      end
      S_RD_A:  state_d = S_RD_X;
      S_RD_X: begin
        // r_q is non-zero here, so r_q-1 cannot wrap.
        if (k_q == r_q - W'(1)) begin
          k_d     = '0;
          state_d = S_RD_B;
        end else begin
          k_d     = k_q + W'(1);
          state_d = S_RD_A;
        end
      end
      S_RD_B:  state_d = S_WR_Y;
      S_WR_Y: begin
        if (col_q < n_q - W'(1)) begin
          col_d = col_q + W'(1);
        end else if (row_q < n_q - W'(1)) begin
          col_d = '0;
          row_d = row_q + W'(1);
        end else begin
          last_elem = 1'b1;
        end
        if (last_elem)       state_d = S_DONE;
        else if (r_q != '0)  state_d = S_RD_A;
        else                 state_d = S_RD_B;
      end
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from the state being entered so they register with it.
  always_comb begin
    opcode_d  = OP_IDLE;
    i_d       = '0;
    j_d       = '0;
    ld_a_d    = 1'b0;
    mac_d     = 1'b0;
    add_b_d   = 1'b0;
    acc_clr_d = 1'b0;
    fin_d     = 1'b0;
    case (state_d)
      S_GET_N: opcode_d = OP_GET_N;
      S_GET_R: opcode_d = OP_GET_R;
      S_RD_A: begin
        opcode_d = OP_READ_A;
        i_d      = row_d;
        j_d      = k_d;
        ld_a_d   = 1'b1;
      end
      S_RD_X: begin
        opcode_d = OP_READ_X;
        i_d      = k_d;
        j_d      = col_d;
        mac_d    = 1'b1;
      end
      S_RD_B: begin
        opcode_d = OP_READ_B;
        i_d      = row_d;
        j_d      = col_d;
        add_b_d  = 1'b1;
      end
      S_WR_Y: begin
        opcode_d  = OP_WR_Y;
        i_d       = row_d;
        j_d       = col_d;
        acc_clr_d = 1'b1;
      end
      S_DONE:  fin_d = 1'b1;
      default: opcode_d = OP_IDLE;
    endcase
  end

  // State, counter and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      n_q       <= '0;
      r_q       <= '0;
      row_q     <= '0;
      col_q     <= '0;
      k_q       <= '0;
      opcode_q  <= OP_IDLE;
      i_q       <= '0;
      j_q       <= '0;
      ld_a_q    <= 1'b0;
      mac_q     <= 1'b0;
      add_b_q   <= 1'b0;
      acc_clr_q <= 1'b0;
      fin_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      r_q       <= r_d;
      row_q     <= row_d;
      col_q     <= col_d;
      k_q       <= k_d;
      opcode_q  <= opcode_d;
      i_q       <= i_d;
      j_q       <= j_d;
      ld_a_q    <= ld_a_d;
      mac_q     <= mac_d;
      add_b_q   <= add_b_d;
      acc_clr_q <= acc_clr_d;
      fin_q     <= fin_d;
    end
  end

  assign opcode  = opcode_q;
  assign i       = i_q;
  assign j       = j_q;
  assign ld_a    = ld_a_q;
  assign mac     = mac_q;
  assign add_b   = add_b_q;
  assign acc_clr = acc_clr_q;
  assign fin     = fin_q;

endmodule

// File: tb/tb_mo_ctrl.sv
// tb_mo_ctrl: scoreboard bench for mo_ctrl. A memory model answers the
// DUT's accesses, a datapath model follows the strobes, and each cycle the
// observed opcode/index/flags are compared against a precomputed trace.
module tb_mo_ctrl;
  localparam int unsigned W = 10;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] in_data;
  logic [2:0]   opcode;
  logic [W-1:0] i, j;
  logic         ld_a, mac, add_b, acc_clr, fin;

  typedef struct {
    int op;
    int i;
    int j;
    int fin;
  } exp_t;

  exp_t exp_q[$];
  int   y_q[$];
  int   ma[4][4], mx[4][4], mb[4][4];
  int   cur_n, cur_r;
  int   a_reg, acc;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  mo_ctrl #(.W(W)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .opcode(opcode),
    .i(i), .j(j), .ld_a(ld_a), .mac(mac), .add_b(add_b),
    .acc_clr(acc_clr), .fin(fin)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Memory model: data for the access the DUT is presenting this cycle.
  function automatic int mem_rd();
    int ii = int'(i);
    int jj = int'(j);
    if (opcode == 3'b000) return cur_n;
    if (opcode == 3'b001) return cur_r;
    if (ii > 3 || jj > 3) return 0;
    case (opcode)
      3'b010:  return ma[ii][jj];
      3'b011:  return mx[ii][jj];
      3'b100:  return mb[ii][jj];
      default: return 0;
    endcase
  endfunction

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_op"}, int'(opcode), 7);
    chk({pfx, "_i"}, int'(i), 0);
    chk({pfx, "_j"}, int'(j), 0);
    chk({pfx, "_strb"}, int'({ld_a, mac, add_b, acc_clr}), 0);
    chk({pfx, "_fin"}, int'(fin), 0);
  endtask

  // Runs one Y = A*X + B job; abort_at >= 0 pulls reset during that cycle.
  task automatic run(input int n, input int r, input int abort_at);
    exp_t e;
    int   idx, first_fin, y;
    cur_n = n;
    cur_r = r;
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++) begin
        ma[a][b] = int'($urandom_range(0, 31));
        mx[a][b] = int'($urandom_range(0, 31));
        mb[a][b] = int'($urandom_range(0, 31));
      end
    exp_q.delete();
    y_q.delete();
    exp_q.push_back('{7, 0, 0, 0});
    exp_q.push_back('{0, 0, 0, 0});
    exp_q.push_back('{1, 0, 0, 0});
    for (int row = 0; row < n; row++)
      for (int col = 0; col < n; col++) begin
        y = mb[row][col];
        for (int k = 0; k < r; k++) begin
          exp_q.push_back('{2, row, k, 0});
          exp_q.push_back('{3, k, col, 0});
          y += ma[row][k] * mx[k][col];
        end
        exp_q.push_back('{4, row, col, 0});
        exp_q.push_back('{5, row, col, 0});
        y_q.push_back(y);
      end
    repeat (3) exp_q.push_back('{7, 0, 0, 1});

    reset   = 1'b0;
    in_data = '0;
    a_reg   = 0;
    acc     = 0;
    repeat (2) @(negedge clk);
    chk_reset_vals("rst");
    reset     = 1'b1;
    idx       = 0;
    first_fin = -1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk($sformatf("op@%0d", idx), int'(opcode), e.op);
      chk($sformatf("i@%0d", idx), int'(i), e.i);
      chk($sformatf("j@%0d", idx), int'(j), e.j);
      chk($sformatf("fin@%0d", idx), int'(fin), e.fin);
      chk($sformatf("onehot@%0d", idx), int'($countones({ld_a, mac, add_b, acc_clr}) <= 1), 1);
      chk($sformatf("ld_a@%0d", idx), int'(ld_a), int'(e.op == 2));
      chk($sformatf("mac@%0d", idx), int'(mac), int'(e.op == 3));
      chk($sformatf("add_b@%0d", idx), int'(add_b), int'(e.op == 4));
      chk($sformatf("acc_clr@%0d", idx), int'(acc_clr), int'(e.op == 5));
      if (fin && first_fin < 0) first_fin = idx;
      if (abort_at == idx) begin
        #2 reset = 1'b0;
        #1 chk_reset_vals("abort");
        exp_q.delete();
        y_q.delete();
        break;
      end
      in_data = W'(mem_rd());
      // Datapath model driven by the DUT strobes.
      if (ld_a)  a_reg = int'(in_data);
      if (mac)   acc   = acc + a_reg * int'(in_data);
      if (add_b) acc   = acc + int'(in_data);
      if (acc_clr) begin
        if (y_q.size() > 0) chk($sformatf("y@%0d", idx), acc, y_q.pop_front());
        else chk($sformatf("y_extra@%0d", idx), 1, 0);
        acc = 0;
      end
      @(posedge clk);
      @(negedge clk);
      idx++;
    end
    if (abort_at < 0) begin
      chk($sformatf("fin_edge n%0d r%0d", n, r), first_fin, 3 + n * n * (2 * r + 2));
      chk("y_left", y_q.size(), 0);
    end
  endtask

  initial begin
    reset   = 1'b0;
    in_data = '0;
    run(2, 3, -1);
    run(1, 1, -1);
    run(3, 0, -1);
    run(0, 5, -1);
    run(3, 2, 3 + 4 * 6 + 2);
    run(3, 2, -1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
